// File: rtl/watch_pkg.sv
// Shared constants for the watch display path: time field positions,
// active-low 7-segment glyphs and buzzer state encodings.
package watch_pkg;

   localparam int HOUR_MSB = 17;
   localparam int HOUR_LSB = 12;
   localparam int MIN_MSB  = 11;
   localparam int MIN_LSB  = 6;
   localparam int SEC_MSB  = 5;
   localparam int SEC_LSB  = 0;

   // Segment order is g..a in bits [6:0]; a 0 lights the segment.
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   localparam logic [1:0] BZ_IDLE     = 2'd0;
   localparam logic [1:0] BZ_BEEP_ON  = 2'd1;
   localparam logic [1:0] BZ_BEEP_OFF = 2'd2;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'd0:    g = SEG_0;
         4'd1:    g = SEG_1;
         4'd2:    g = SEG_2;
         4'd3:    g = SEG_3;
         4'd4:    g = SEG_4;
         4'd5:    g = SEG_5;
         4'd6:    g = SEG_6;
         4'd7:    g = SEG_7;
         4'd8:    g = SEG_8;
         4'd9:    g = SEG_9;
         default: g = SEG_BLANK;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/bin2bcd_60.sv
// Combinational 6-bit binary to two decimal digits, using a threshold
// chain instead of a divider; valid is high for values 0..59.
module bin2bcd_60
   import watch_pkg::*;
(
   input  logic [5:0] bin,
   output logic [3:0] tens,
   output logic [3:0] units,
   output logic       valid
);

   // Units are taken modulo 16, so subtracting (base mod 16) from the low
   // nibble yields the remainder without a full-width subtract.
   always_comb begin
      tens  = 4'd0;
      units = bin[3:0];
      if (bin >= 6'd60) begin
         tens  = 4'd6;
         units = bin[3:0] - 4'd12;
      end else if (bin >= 6'd50) begin
         tens  = 4'd5;
         units = bin[3:0] - 4'd2;
      end else if (bin >= 6'd40) begin
         tens  = 4'd4;
         units = bin[3:0] - 4'd8;
      end else if (bin >= 6'd30) begin
         tens  = 4'd3;
         units = bin[3:0] - 4'd14;
      end else if (bin >= 6'd20) begin
         tens  = 4'd2;
         units = bin[3:0] - 4'd4;
      end else if (bin >= 6'd10) begin
         tens  = 4'd1;
         units = bin[3:0] - 4'd10;
      end
   end

   assign valid = (bin <= 6'd59);

endmodule

// File: rtl/watch_display.sv
// Six-digit multiplexed HH:MM:SS display with per-frame time snapshot,
// 12/24-hour formatting, colon blink and a gated alarm tone.
module watch_display
   import watch_pkg::*;
#(
   parameter int scan_cnt  = 50000,
   parameter int tone_half = 25000,
   parameter int gate_len  = 5000000,
   parameter int cnt_w     = 24
)(
   input  logic        clock,
   input  logic        reset,
   input  logic [17:0] time_data,
   input  logic        am_pm_div,
   input  logic        alerm_equal,
   output logic [7:0]  seg,
   output logic [5:0]  digit_sel,
   output logic        buzzer
);

   logic [cnt_w-1:0] pre_q, pre_d;
   logic [2:0]       idx_q, idx_d;
   logic             load_pending_q, load_pending_d;
   logic [17:0]      snap_time_q, snap_time_d;
   logic             snap_12h_q, snap_12h_d;
   logic [7:0]       seg_q, seg_d;
   logic [5:0]       digit_sel_q, digit_sel_d;
   logic [1:0]       bz_state_q, bz_state_d;
   logic [cnt_w-1:0] tone_q, tone_d;
   logic [cnt_w-1:0] gate_q, gate_d;
   logic             buzz_q, buzz_d;

   logic             pre_term;
   logic             frame_end;

   assign pre_term  = (pre_q == cnt_w'(scan_cnt - 1));
   assign frame_end = pre_term && (idx_q == 3'd5);

   always_comb begin
      pre_d          = pre_term ? '0 : pre_q + 1'b1;
      idx_d          = idx_q;
      if (pre_term) begin
         idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end
      load_pending_d = 1'b0;
      snap_time_d    = snap_time_q;
      snap_12h_d     = snap_12h_q;
      // Only take new time at frame boundaries so a frame never mixes two times.
      if (load_pending_q || frame_end) begin
         snap_time_d = time_data;
         snap_12h_d  = am_pm_div;
      end
   end

   logic [5:0] hour, minute, second;
   logic [5:0] hour_disp;
   logic       hour_in_range, hour_pm;

   assign hour          = snap_time_q[HOUR_MSB:HOUR_LSB];
   assign minute        = snap_time_q[MIN_MSB:MIN_LSB];
   assign second        = snap_time_q[SEC_MSB:SEC_LSB];
   assign hour_in_range = (hour <= 6'd23);
   assign hour_pm       = snap_12h_q && hour_in_range && (hour >= 6'd12);

   always_comb begin
      hour_disp = hour;
      if (snap_12h_q && hour_in_range) begin
         if (hour == 6'd0) begin
            hour_disp = 6'd12;
         end else if (hour > 6'd12) begin
            hour_disp = hour - 6'd12;
         end
      end
   end

   logic [3:0] sec_t, sec_u, min_t, min_u, hr_t, hr_u;
   logic       sec_ok, min_ok, hr_bcd_ok, hour_ok;

   bin2bcd_60 u_sec (.bin(second),    .tens(sec_t), .units(sec_u), .valid(sec_ok));
   bin2bcd_60 u_min (.bin(minute),    .tens(min_t), .units(min_u), .valid(min_ok));
   bin2bcd_60 u_hr  (.bin(hour_disp), .tens(hr_t),  .units(hr_u),  .valid(hr_bcd_ok));

   assign hour_ok = hour_in_range && hr_bcd_ok;

   // Colon dots on digits 2 and 4 blink with the seconds (lit on even).
   always_comb begin
      seg_d       = {1'b1, SEG_BLANK};
      digit_sel_d = ~(6'b000001 << idx_q);
      case (idx_q)
         3'd0: seg_d = {1'b1, sec_ok ? seg_of(sec_u) : SEG_DASH};
         3'd1: seg_d = {1'b1, sec_ok ? seg_of(sec_t) : SEG_DASH};
         3'd2: seg_d = {second[0], min_ok ? seg_of(min_u) : SEG_DASH};
         3'd3: seg_d = {1'b1, min_ok ? seg_of(min_t) : SEG_DASH};
         3'd4: seg_d = {second[0], hour_ok ? seg_of(hr_u) : SEG_DASH};
         3'd5: begin
            if (!hour_ok) begin
               seg_d = {~hour_pm, SEG_DASH};
            end else if (snap_12h_q && (hr_t == 4'd0)) begin
               seg_d = {~hour_pm, SEG_BLANK};
            end else begin
               seg_d = {~hour_pm, seg_of(hr_t)};
            end
         end
         default: seg_d = {1'b1, SEG_BLANK};
      endcase
   end

   logic tone_last, gate_last;

   assign tone_last = (tone_q == cnt_w'(tone_half - 1));
   assign gate_last = (gate_q == cnt_w'(gate_len - 1));

   always_comb begin
      bz_state_d = bz_state_q;
      tone_d     = tone_q;
      gate_d     = gate_q;
      buzz_d     = buzz_q;
      if (!alerm_equal) begin
         bz_state_d = BZ_IDLE;
         tone_d     = '0;
         gate_d     = '0;
         buzz_d     = 1'b0;
      end else begin
         case (bz_state_q)
            BZ_IDLE: begin
               bz_state_d = BZ_BEEP_ON;
               tone_d     = '0;
               gate_d     = '0;
               buzz_d     = 1'b0;
            end
            BZ_BEEP_ON: begin
               if (gate_last) begin
                  bz_state_d = BZ_BEEP_OFF;
                  gate_d     = '0;
                  tone_d     = '0;
                  buzz_d     = 1'b0;
               end else begin
                  gate_d = gate_q + 1'b1;
                  if (tone_last) begin
                     tone_d = '0;
                     buzz_d = ~buzz_q;
                  end else begin
                     tone_d = tone_q + 1'b1;
                  end
               end
            end
            BZ_BEEP_OFF: begin
               buzz_d = 1'b0;
               tone_d = '0;
               if (gate_last) begin
                  bz_state_d = BZ_BEEP_ON;
                  gate_d     = '0;
               end else begin
                  gate_d = gate_q + 1'b1;
               end
            end
            default: begin
               bz_state_d = BZ_IDLE;
               tone_d     = '0;
               gate_d     = '0;
               buzz_d     = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pre_q          <= '0;
         idx_q          <= 3'd0;
         load_pending_q <= 1'b1;
         snap_time_q    <= '0;
         snap_12h_q     <= 1'b0;
         seg_q          <= 8'hFF;
         digit_sel_q    <= 6'b111111;
         bz_state_q     <= BZ_IDLE;
         tone_q         <= '0;
         gate_q         <= '0;
         buzz_q         <= 1'b0;
      end else begin
         pre_q          <= pre_d;
         idx_q          <= idx_d;
         load_pending_q <= load_pending_d;
         snap_time_q    <= snap_time_d;
         snap_12h_q     <= snap_12h_d;
         seg_q          <= seg_d;
         digit_sel_q    <= digit_sel_d;
         bz_state_q     <= bz_state_d;
         tone_q         <= tone_d;
         gate_q         <= gate_d;
         buzz_q         <= buzz_d;
      end
   end

   assign seg       = seg_q;
   assign digit_sel = digit_sel_q;
   assign buzzer    = buzz_q;

endmodule

// File: doc/watch_display.md
Name: watch_display

Overview:
- Output-side consumer of the watch control block's `time_data`, `am_pm_div` and `alerm_equal` outputs.
- Drives a 6-digit multiplexed 7-segment display showing HH:MM:SS and a gated piezo buzzer.
- Converts binary fields to decimal digits and applies 12/24-hour formatting.
- Snapshots time once per scan frame so the display never tears mid-frame.

Parameters:
- `scan_cnt`, 50000: clock cycles each digit stays enabled (>=2).
- `tone_half`, 25000: clock cycles per buzzer tone half-period (>=1).
- `gate_len`, 5000000: clock cycles per beep on-phase; the off-phase is equal length (>=1).
- `cnt_w`, 24: width of the prescaler/tone/gate counters; must hold max(param)-1.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `time_data` in 18: binary time; [17:12] hour 0-23, [11:6] minute 0-59, [5:0] second 0-59.
- `am_pm_div` in 1: 1 = 12-hour display, 0 = 24-hour display.
- `alerm_equal` in 1: level, high while the alarm is sounding.
- `seg` out 8: active-low segments; [6:0] = g..a, [7] = dp.
- `digit_sel` out 6: active-low one-hot digit enable; bit0 = second units ... bit5 = hour tens.
- `buzzer` out 1: tone output.

Behaviour:
- Reset (`reset` = 0, async):
  - `seg` = 8'hFF, `digit_sel` = 6'b111111, `buzzer` = 0.
  - Prescaler, digit index, tone and gate counters = 0.
  - Snapshot = 0, `load_pending` = 1.
- Snapshot load:
  - Loads `time_data` and `am_pm_div` on the first clock edge with `load_pending` = 1, which then clears.
  - Thereafter loads on the edge where the prescaler is terminal and the index is 5 (index wraps to 0).
  - Input changes mid-frame are not visible until the next frame.
- Scan timing:
  - Prescaler counts 0..`scan_cnt`-1, then wraps.
  - Index advances 0→1→…→5→0 on the prescaler terminal.
  - One frame = 6·`scan_cnt` clocks.
- Output registration:
  - `seg` and `digit_sel` are registered from the current index and snapshot; latency is 1 clock.
  - Exactly one `digit_sel` bit is low at any time after the first post-reset edge.
- Decimal conversion:
  - Each 6-bit field is split into tens = v/10 and units = v%10 by a comparison chain; no divider.
- Range check:
  - Field out of range (hour > 23, or minute/second > 59): both digits of that pair show a dash (g only: 7'b0111111).
  - Other pairs are unaffected.
- 12-hour mode (snapshot `am_pm_div` = 1):
  - Displayed hour: 0→12, 1..12 unchanged, 13..23 → h-12.
  - Hour-tens digit is blanked (7'b1111111) when zero.
  - dp of the hour-tens digit is lit (0) when the actual hour >= 12 (PM).
- 24-hour mode: leading zero is shown; no PM dp.
- Separators: dp of digit 2 and digit 4 lit when snapshot second is even, dark when odd (colon blink). All other dp stay dark.
- Buzzer state machine, states IDLE / BEEP_ON / BEEP_OFF:
  - IDLE→BEEP_ON when `alerm_equal` = 1; tone and gate counters start from 0.
  - BEEP_ON: `buzzer` toggles every `tone_half` clocks. After `gate_len` clocks go to BEEP_OFF with `buzzer` forced to 0.
  - BEEP_OFF: silent for `gate_len` clocks, then BEEP_ON.
  - From any state, `alerm_equal` = 0 → IDLE next edge, `buzzer` = 0, counters cleared.
  - `alerm_equal` is sampled every clock, not snapshotted.
- Reset mid-frame or mid-beep: immediately returns to the reset values above. The next frame reloads via `load_pending`.

Decomposition:
- Package `watch_pkg` holds:
  - Field bit ranges: HOUR 17:12, MIN 11:6, SEC 5:0.
  - 7-segment constants SEG_0..SEG_9, SEG_BLANK, SEG_DASH.
  - Buzzer state encodings.
- One sub-module `bin2bcd_60`: 6-bit binary in → 4-bit tens, 4-bit units, valid flag (v <= 59); combinational.
  - Instantiate three times.
  - Hour validity is checked separately against 23.

Test Plan (`scan_cnt` = 2, `tone_half` = 2, `gate_len` = 8):
1. Hold `reset` low 4 clocks → `seg` = FF, `digit_sel` = 3F, `buzzer` = 0. Release → `digit_sel` = 3E one clock later. `digit_sel` walks 3E,3D,3B,37,2F,1F, each for 2 clocks, then repeats.
2. Input `time_data` = {14,35,08}, `am_pm_div` = 0 → digit codes 1,4,3,5,0,8 (hour tens first). Digit 2/4 dp lit (second 8 is even). No PM dp.
3. Same time with `am_pm_div` = 1 → hour shows blank,2 with PM dp lit. Then hour 0 → 1,2 with no PM dp. Then hour 12 → 1,2 with PM dp lit.
4. Change `time_data` during digit 3 of a frame → display is unchanged until the edge after the index wraps 5→0; the new value appears from that frame on.
5. Input hour = 25, minute = 61 → hour and minute pairs show SEG_DASH; the second pair is correct.
6. Raise `alerm_equal` → `buzzer` toggles every 2 clocks for 8 clocks, is low for 8 clocks, then repeats. Drop `alerm_equal` mid-BEEP_ON → `buzzer` = 0 next clock. Reassert → the pattern restarts from 0.
